// File: rtl/wb_pkg.sv
// Shared widths, the queued write-back entry and the arbiter state encoding.
package wb_pkg;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {IDLE, QUEUED, STARVED} state_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular queue of MDU results with per-entry kill and source-register compare.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_entry_t     push_entry,
  input  logic          pop,
  input  logic          kill,
  input  logic [AW-1:0] kill_addr,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output wb_entry_t     head,
  output logic [CW-1:0] count,
  output logic          rs_hit,
  output logic          rt_hit
);
  wb_entry_t      mem_reg [DEPTH];
  logic [PW-1:0]  head_reg, tail_reg;
  logic [CW-1:0]  count_reg;
  logic [DEPTH-1:0] rs_match, rt_match;

  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Valid is cleared on pop, so a set valid bit always means an occupied slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && tail_reg == PW'(i))
          mem_reg[i] <= push_entry;
        else if (pop && head_reg == PW'(i))
          mem_reg[i].valid <= 1'b0;
        else if (kill && mem_reg[i].addr == kill_addr)
          mem_reg[i].valid <= 1'b0;
      end
      if (push) tail_reg <= adv(tail_reg);
      if (pop)  head_reg <= adv(head_reg);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign rs_match[gi] = mem_reg[gi].valid && (mem_reg[gi].addr == rs_addr);
      assign rt_match[gi] = mem_reg[gi].valid && (mem_reg[gi].addr == rt_addr);
    end
  endgenerate

  assign head   = mem_reg[head_reg];
  assign count  = count_reg;
  assign rs_hit = (rs_addr != '0) && (|rs_match);
  assign rt_hit = (rt_addr != '0) && (|rt_match);
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline WB stage and the MDU,
// queueing MDU results and stalling the pipeline when a queued result starves.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_waddr,
  input  logic [DW-1:0] pipe_wdata,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [AW-1:0] mdu_waddr,
  input  logic [DW-1:0] mdu_wdata,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic          rs_pend,
  output logic          rt_pend,
  output logic          pipe_stall,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic          pipe_wr, pop, push, bypass, xfer, full, mdu_drop;
  logic [CW-1:0] count, count_next;
  logic [WW-1:0] wait_reg, wait_next;
  wb_entry_t     head, push_entry;
  state_t        state_reg, state_next;
  logic          we_next;
  logic [AW-1:0] waddr_next;
  logic [DW-1:0] wdata_next;
  logic          rf_we_reg;
  logic [AW-1:0] rf_waddr_reg;
  logic [DW-1:0] rf_wdata_reg;

  assign pipe_wr   = pipe_we && (pipe_waddr != '0);
  assign pop       = (count != '0) && !pipe_wr;
  assign full      = (count == CW'(DEPTH));
  assign mdu_ready = !rst && (!full || pop);
  assign xfer      = mdu_valid && mdu_ready;
  assign bypass    = xfer && (count == '0) && !pipe_wr;
  // $0 results and results overwritten by a same-cycle pipeline write are handshaken but never stored.
  assign mdu_drop  = (mdu_waddr == '0) || (pipe_wr && mdu_waddr == pipe_waddr);
  assign push      = xfer && !bypass && !mdu_drop;
  assign push_entry = '{valid: 1'b1, addr: mdu_waddr, data: mdu_wdata};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill       (pipe_wr),
    .kill_addr  (pipe_waddr),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .head       (head),
    .count      (count),
    .rs_hit     (rs_pend),
    .rt_hit     (rt_pend)
  );

  always_comb begin
    we_next    = 1'b0;
    waddr_next = '0;
    wdata_next = '0;
    count_next = count + CW'(push) - CW'(pop);
    if (pipe_wr) begin
      we_next    = 1'b1;
      waddr_next = pipe_waddr;
      wdata_next = pipe_wdata;
    end else if (pop) begin
      if (head.valid) begin
        we_next    = 1'b1;
        waddr_next = head.addr;
        wdata_next = head.data;
      end
    end else if (bypass && mdu_waddr != '0) begin
      we_next    = 1'b1;
      waddr_next = mdu_waddr;
      wdata_next = mdu_wdata;
    end

    if (count == '0 || pop)              wait_next = '0;
    else if (wait_reg == WW'(MAX_WAIT))  wait_next = wait_reg;
    else                                 wait_next = wait_reg + 1'b1;

    if (count_next == '0)                state_next = IDLE;
    else if (wait_next == WW'(MAX_WAIT)) state_next = STARVED;
    else                                 state_next = QUEUED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_reg     <= '0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_reg     <= wait_next;
      rf_we_reg    <= we_next;
      rf_waddr_reg <= waddr_next;
      rf_wdata_reg <= wdata_next;
    end
  end

  assign pipe_stall = (state_reg == STARVED);
  assign rf_we      = rf_we_reg;
  assign rf_waddr   = rf_waddr_reg;
  assign rf_wdata   = rf_wdata_reg;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboarded bench: expected register-file writes are queued at drive time, matched on output.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_pend, rt_pend, pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_pend(rs_pend), .rt_pend(rt_pend),
    .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md);
    pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    sb.push_back({a, d});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rf_we === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_we", 64'(rf_we), 64'd0);
        end else begin
          logic [36:0] e;
          e = sb.pop_front();
          chk("wr_addr", 64'(rf_waddr), 64'(e[36:32]));
          chk("wr_data", 64'(rf_wdata), 64'(e[31:0]));
        end
      end else begin
        chk("idle_wdata", 64'(rf_wdata), 64'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    rs_addr = '0; rt_addr = '0;
    drv(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_stall", 64'(pipe_stall), 64'd0);
    chk("rst_ready", 64'(mdu_ready), 64'd0);
    rst = 1'b0; mon_en = 1'b1;
    #1 chk("ready_after_rst", 64'(mdu_ready), 64'd1);

    // pipeline only, then a discarded write to $0
    drv(1, 8, 32'hDEADBEEF, 0, 0, 0); expect_wr(8, 32'hDEADBEEF);
    tick();
    chk("pipe_we", 64'(rf_we), 64'd1);
    drv(1, 0, 32'h12345678, 0, 0, 0);
    tick();
    chk("zero_we", 64'(rf_we), 64'd0);
    chk("zero_wdata", 64'(rf_wdata), 64'd0);

    // MDU bypass
    drv(0, 0, 0, 1, 9, 32'h1234); rs_addr = 9;
    #1 chk("byp_ready", 64'(mdu_ready), 64'd1);
    expect_wr(9, 32'h1234);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    #1 chk("byp_no_pend", 64'(rs_pend), 64'd0);
    tick();

    // fill and backpressure
    drv(1, 10, 32'hA0, 1, 11, 32'hC1);
    #1 chk("fill_ready0", 64'(mdu_ready), 64'd1);
    expect_wr(10, 32'hA0); tick();
    drv(1, 10, 32'hA1, 1, 12, 32'hC2);
    #1 chk("fill_ready1", 64'(mdu_ready), 64'd1);
    expect_wr(10, 32'hA1); tick();
    drv(1, 10, 32'hA2, 1, 13, 32'hC3); rs_addr = 11; rt_addr = 12;
    #1 chk("full_ready", 64'(mdu_ready), 64'd0);
    chk("rs_pend_q", 64'(rs_pend), 64'd1);
    chk("rt_pend_q", 64'(rt_pend), 64'd1);
    expect_wr(10, 32'hA2); tick();
    drv(0, 0, 0, 1, 13, 32'hC3);
    #1 chk("pop_push_ready", 64'(mdu_ready), 64'd1);
    expect_wr(11, 32'hC1); tick();
    drv(0, 0, 0, 0, 0, 0);
    expect_wr(12, 32'hC2); tick();
    expect_wr(13, 32'hC3); tick();
    #1 chk("drained_pend", 64'(rs_pend), 64'd0);
    tick();

    // starvation
    drv(1, 20, 32'hB0, 1, 21, 32'hCC);
    expect_wr(20, 32'hB0); tick();
    for (int k = 1; k <= 4; k++) begin
      drv(1, 20, 32'hB0 + 32'(k), 0, 0, 0);
      chk("stall_wait", 64'(pipe_stall), 64'd0);
      expect_wr(20, 32'hB0 + 32'(k)); tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    chk("stall_set", 64'(pipe_stall), 64'd1);
    expect_wr(21, 32'hCC); tick();
    chk("stall_clear", 64'(pipe_stall), 64'd0);
    chk("starved_we", 64'(rf_we), 64'd1);

    // WAW kill of a queued entry
    drv(1, 22, 32'h22, 1, 5, 32'hAAAA);
    expect_wr(22, 32'h22); tick();
    drv(1, 5, 32'hBBBB, 0, 0, 0); rs_addr = 5;
    #1 chk("waw_pend", 64'(rs_pend), 64'd1);
    expect_wr(5, 32'hBBBB); tick();
    drv(0, 0, 0, 0, 0, 0);
    #1 chk("waw_pend_clr", 64'(rs_pend), 64'd0);
    tick(); tick();

    // incoming MDU result killed by a same-cycle pipeline write, and an MDU write to $0
    drv(1, 6, 32'h1111, 1, 6, 32'h2222); rt_addr = 6;
    #1 chk("kill_in_ready", 64'(mdu_ready), 64'd1);
    expect_wr(6, 32'h1111); tick();
    drv(0, 0, 0, 0, 0, 0);
    #1 chk("kill_in_pend", 64'(rt_pend), 64'd0);
    tick();
    drv(0, 0, 0, 1, 0, 32'h55);
    #1 chk("zero_mdu_ready", 64'(mdu_ready), 64'd1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    tick(); tick();

    // reset mid-operation with a full, starved queue
    drv(1, 23, 32'hD0, 1, 24, 32'hE0); expect_wr(23, 32'hD0); tick();
    drv(1, 23, 32'hD1, 1, 25, 32'hE1); expect_wr(23, 32'hD1); tick();
    for (int k = 2; k <= 4; k++) begin
      drv(1, 23, 32'hD0 + 32'(k), 0, 0, 0);
      expect_wr(23, 32'hD0 + 32'(k)); tick();
    end
    drv(1, 23, 32'hD5, 1, 26, 32'hE6); rs_addr = 24;
    #1 chk("pre_rst_stall", 64'(pipe_stall), 64'd1);
    chk("pre_rst_ready", 64'(mdu_ready), 64'd0);
    chk("pre_rst_pend", 64'(rs_pend), 64'd1);
    expect_wr(23, 32'hD5); tick();
    rst = 1'b1; drv(0, 0, 0, 0, 0, 0);
    #1 chk("in_rst_ready", 64'(mdu_ready), 64'd0);
    tick();
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_waddr", 64'(rf_waddr), 64'd0);
    chk("mid_rst_stall", 64'(pipe_stall), 64'd0);
    rst = 1'b0;
    #1 chk("post_rst_ready", 64'(mdu_ready), 64'd1);
    chk("post_rst_pend", 64'(rs_pend), 64'd0);
    tick(); tick(); tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
